// File: rtl/fpro_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : fpro_bus_master
//  Purpose  : Initiator-side burst engine for the FPro MMIO bus. Accepts
//             read/write burst commands on a valid/ready port, drives the
//             MMIO strobes/address/write data, and returns read beats through
//             a one-entry response register.
//  Ports    : clk, reset (async, active-low)
//             cmd_*  : burst command (write flag, start address, beats-1)
//             wr_*   : write-data beat stream
//             rsp_*  : read-data beat stream with last-beat flag
//             busy   : engine is not idle
//             mmio_* : FPro bus toward the MMIO controller
//  Revision : 1.0 - initial release
// ============================================================================
module fpro_bus_master #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  busy,
    output logic                  mmio_cs,
    output logic                  mmio_read,
    output logic                  mmio_write,
    output logic [ADDR_WIDTH-1:0] mmio_addr,
    output logic [DATA_WIDTH-1:0] mmio_wr_data,
    input  logic [DATA_WIDTH-1:0] mmio_rd_data
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_write = 2'd1;
    localparam logic [1:0] c_read  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_rsp_valid;
    logic                  r_rsp_last;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  w_cmd_fire;
    logic                  w_wr_beat;
    logic                  w_rd_beat;
    logic                  w_cnt_zero;
    logic [ADDR_WIDTH-1:0] w_addr_inc;

    assign w_cnt_zero = (r_cnt == '0);
    // Only the register field advances; the slot field is pinned so a burst
    // can never spill into a neighbouring slot.
    assign w_addr_inc = {r_addr[ADDR_WIDTH-1:5], r_addr[4:0] + 5'd1};

    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;
        w_cmd_fire   = 1'b0;
        w_wr_beat    = 1'b0;
        w_rd_beat    = 1'b0;
        case (r_state)
            c_idle: begin
                cmd_ready  = 1'b1;
                w_cmd_fire = cmd_valid;
                if (cmd_valid)
                    w_next_state = cmd_write ? c_write : c_read;
            end
            c_write: begin
                wr_ready  = 1'b1;
                w_wr_beat = wr_valid;
                if (wr_valid && w_cnt_zero)
                    w_next_state = c_idle;
            end
            c_read: begin
                // Issue only when the single response slot is free, or is
                // being emptied on this very edge.
                w_rd_beat = !r_rsp_valid || rsp_ready;
                if (w_rd_beat && w_cnt_zero)
                    w_next_state = c_idle;
            end
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_idle;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_cmd_fire) begin
                r_addr <= cmd_addr;
                r_cnt  <= cmd_len;
            end else if (w_wr_beat || w_rd_beat) begin
                r_addr <= w_addr_inc;
                r_cnt  <= r_cnt - LEN_WIDTH'(1);
            end
        end
    end

    // Response register drains independently of the FSM so the engine can
    // return to idle while the final beat is still waiting for the consumer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_rd_beat) begin
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= w_cnt_zero;
            r_rsp_data  <= mmio_rd_data;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_last     = r_rsp_last;
    assign rsp_data     = r_rsp_data;
    assign busy         = (r_state != c_idle);
    assign mmio_cs      = w_wr_beat || w_rd_beat;
    assign mmio_write   = w_wr_beat;
    assign mmio_read    = w_rd_beat;
    assign mmio_addr    = r_addr;
    assign mmio_wr_data = w_wr_beat ? wr_data : '0;

endmodule
`default_nettype wire

// File: doc/fpro_bus_master.md
# fpro_bus_master

Initiator-side engine for the FPro MMIO bus: accepts read/write burst commands on a valid/ready interface and drives `mmio_cs`/`mmio_read`/`mmio_write`/`mmio_addr`/`mmio_wr_data` toward the MMIO controller, returning read data on a buffered response stream. It sits beside the MicroBlaze MCS as a second bus source, for example behind a debug UART or a test sequencer, with an external arbiter selecting between the two. The slot/register address layout matches the MMIO controller: addr[10:5] is the slot and addr[4:0] is the register.

## Interface
- ADDR_WIDTH, 21, FPro bus address width.
- DATA_WIDTH, 32, FPro bus data width.
- LEN_WIDTH, 4, burst length field; beats = cmd_len + 1 (1..16).

- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low (0 = reset).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when both valid and ready are high.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  ADDR_WIDTH  start address.
- cmd_len  input  LEN_WIDTH  beats minus one.
- wr_valid  input  1  write-data beat present.
- wr_ready  output  1  write beat consumed.
- wr_data  input  DATA_WIDTH  write beat data.
- rsp_valid  output  1  read beat available.
- rsp_ready  input  1  read beat consumed.
- rsp_data  output  DATA_WIDTH  read beat data.
- rsp_last  output  1  final beat of the read burst.
- busy  output  1  state is not IDLE.
- mmio_cs, mmio_read, mmio_write  output  1 each  bus strobes.
- mmio_addr  output  ADDR_WIDTH  bus address.
- mmio_wr_data  output  DATA_WIDTH  bus write data.
- mmio_rd_data  input  DATA_WIDTH  bus read data; combinational and valid in the same cycle as mmio_read.

## Operation
- FSM states: IDLE, WRITE, READ.
- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid, latch addr, len and direction; beat counter = cmd_len.
  - Next state is WRITE or READ according to cmd_write.
- **WRITE**
  - wr_ready = 1.
  - In every cycle with wr_valid = 1: mmio_cs = mmio_write = 1, mmio_wr_data = wr_data, mmio_addr = current address.
  - Each such cycle advances the address and decrements the counter.
  - The cycle in which counter = 0 and wr_valid = 1 is the last beat; the next state is IDLE.
  - Cycles with wr_valid = 0 are stalls: strobes stay low.
- **READ**
  - A beat issues (mmio_cs = mmio_read = 1) when the response register is empty, or is being drained in the same cycle (rsp_valid & rsp_ready).
  - mmio_rd_data is captured into rsp_data on that clock edge.
  - rsp_valid is set, and rsp_last is set if counter = 0.
  - After the last beat issues, the next state is IDLE. The response register drains independently of the FSM.
- **Address increment**
  - addr[4:0] increments modulo 32; addr[ADDR_WIDTH-1:5] is held for the whole burst.
  - A burst therefore never leaves its slot. Example: start 0x03E with 4 beats gives addresses 0x03E, 0x03F, 0x020, 0x021.
- **Strobe rules**
  - mmio_read and mmio_write are never high together.
  - All strobes are 0 in IDLE.
  - All strobes are decoded combinationally from the registered state and the handshake inputs.
- **Response register**
  - One entry.
  - rsp_data, rsp_last and rsp_valid hold until rsp_ready.
- **busy** = (state != IDLE). It does not cover a pending response.

## Timing
- **Reset values**
  - state IDLE, so cmd_ready = 1; commands presented while reset = 0 are ignored.
  - wr_ready, rsp_valid, rsp_last, busy, mmio_cs, mmio_read, mmio_write all 0.
  - mmio_addr, mmio_wr_data, rsp_data all 0.
- **Reset mid-burst:** strobes drop asynchronously, the in-flight response is discarded, and the remaining beats are abandoned.
- **Command acceptance:** accept at edge N; the first bus strobe is possible in cycle N+1.
- **Write throughput:** 1 beat per cycle when wr_valid is held high. An N-beat burst occupies N+1 cycles including acceptance.
- **Read latency:** strobe in cycle N, rsp_valid high from cycle N+1.
- **Read throughput:** 1 beat per cycle while rsp_ready is held high. If rsp_ready is low, exactly one beat is buffered and the bus is idle until it drains.
- **Back-to-back commands:** the next command is accepted in the IDLE cycle following the last beat. A new read is held off until the prior response drains.

## Test plan
- **Single write:** cmd addr 0x0A0, len 0, write; wr_data 0xDEADBEEF -> exactly one cycle with mmio_cs = mmio_write = 1, addr 0x0A0, data 0xDEADBEEF; busy falls the next cycle.
- **Read burst, rsp_ready held 1:** addr 0x0A0, len 3; bus model returns addr+0x100 -> responses 0x1A0, 0x1A1, 0x1A2, 0x1A3 on consecutive cycles; rsp_last only on 0x1A3; four strobe cycles in total.
- **Read backpressure:** same burst with rsp_ready held 0 for 5 cycles after the first rsp_valid -> exactly one strobe issues, rsp_data stays 0x1A0, no further mmio_read until rsp_ready.
- **Slot wrap:** write burst, addr 0x03E, len 3 -> bus addresses 0x03E, 0x03F, 0x020, 0x021.
- **Write stalls:** wr_valid toggles 1,0,1,0,1 for a 3-beat burst -> strobes only in the valid cycles, addresses increment only on beats, IDLE after the third beat.
- **Reset mid-read:** assert reset after beat 2 of a 16-beat read -> all strobes and rsp_valid go to 0 immediately; after release cmd_ready = 1 and a new single read completes normally.
